// File: rtl/regfile_dump_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_dump_sequencer
//
// Walks the register file through the decode stage's debug read port and
// streams every register out, MSB byte first, over a valid/ready byte
// handshake towards the UART transmitter.
//
// Each register word is snapshotted in LOAD and then shifted out of a
// private shift register in SEND. Later register-file writes therefore
// cannot corrupt a word that has already been captured.
//
// Ports
//   i_clk                   clock, rising edge
//   i_reset                 asynchronous reset, active low
//   i_start                 begin a dump (only honoured in IDLE; wins over abort)
//   i_abort                 cancel an in-progress dump, no done pulse
//   o_mips_register_number  register index towards the decode debug port
//   i_data_tx_debug         word returned for that index (combinational)
//   o_tx_data               byte offered to the transmitter
//   o_tx_valid              o_tx_data is valid
//   i_tx_ready              transmitter accepts the byte this cycle
//   o_busy                  high whenever the sequencer is not idle
//   o_done                  one-cycle pulse after the final byte is accepted
// -----------------------------------------------------------------------------
module regfile_dump_sequencer #(
    parameter int NB    = 32,
    parameter int REGS  = 5,
    parameter int NREGS = 32,
    parameter int BYTE  = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_abort,
    output logic [REGS-1:0] o_mips_register_number,
    input  logic [NB-1:0]   i_data_tx_debug,
    output logic [BYTE-1:0] o_tx_data,
    output logic            o_tx_valid,
    input  logic            i_tx_ready,
    output logic            o_busy,
    output logic            o_done
);

    localparam int NBYTES = NB / BYTE;
    // Keep the byte counter at least one bit wide even for one-byte words.
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [CW-1:0]   LAST_BYTE = CW'(NBYTES - 1);
    localparam logic [REGS-1:0] LAST_REG  = REGS'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [REGS-1:0] index_reg, index_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [NB-1:0]   shift_reg, shift_next;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            count_reg <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            count_reg <= count_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        count_next = count_reg;
        shift_next = shift_reg;

        // Abort outranks everything, including a byte transfer in the same
        // cycle; the datapath simply holds since it is reloaded on restart.
        if (i_abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        index_next = '0;
                        state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Index has been stable on the debug port since the
                    // previous edge, so the returned word is settled here.
                    shift_next = i_data_tx_debug;
                    count_next = '0;
                    state_next = ST_SEND;
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        shift_next = shift_reg << BYTE;
                        count_next = count_reg + CW'(1);
                        if (count_reg == LAST_BYTE) begin
                            if (index_reg == LAST_REG) begin
                                state_next = ST_DONE;
                            end else begin
                                index_next = index_reg + REGS'(1);
                                state_next = ST_LOAD;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Every output is a register or a pure state decode: i_tx_ready never
    // reaches an output combinationally, and data/valid cannot move while
    // a byte is stalled.
    assign o_mips_register_number = index_reg;
    assign o_tx_data              = shift_reg[NB-1 -: BYTE];
    assign o_tx_valid             = (state_reg == ST_SEND);
    assign o_busy                 = (state_reg != ST_IDLE);
    assign o_done                 = (state_reg == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_dump_sequencer.
// A 32-entry register-file model answers the debug port of two instances:
// the default build (NREGS=32) and a small build (NREGS=4) sharing stimulus.
// Cycle n is the n-th cycle after the edge that samples i_start; outputs are
// sampled on the falling edge, inputs change on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_regfile_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tx_ready = 1'b1;

    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic [4:0]  reg_num4;
    logic [31:0] reg_data4;
    logic [7:0]  tx_data4;
    logic        tx_valid4;
    logic        busy4;
    logic        done4;

    logic [31:0] regs [0:31];

    assign reg_data  = regs[reg_num];
    assign reg_data4 = regs[reg_num4];

    always #5 clk = ~clk;

    regfile_dump_sequencer dut (
        .i_clk                  (clk),
        .i_reset                (rst_n),
        .i_start                (start),
        .i_abort                (abort),
        .o_mips_register_number (reg_num),
        .i_data_tx_debug        (reg_data),
        .o_tx_data              (tx_data),
        .o_tx_valid             (tx_valid),
        .i_tx_ready             (tx_ready),
        .o_busy                 (busy),
        .o_done                 (done)
    );

    regfile_dump_sequencer #(.NREGS(4)) dut4 (
        .i_clk                  (clk),
        .i_reset                (rst_n),
        .i_start                (start),
        .i_abort                (abort),
        .o_mips_register_number (reg_num4),
        .i_data_tx_debug        (reg_data4),
        .o_tx_data              (tx_data4),
        .o_tx_valid             (tx_valid4),
        .i_tx_ready             (tx_ready),
        .o_busy                 (busy4),
        .o_done                 (done4)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    // Results of the most recent dump.
    logic [7:0] got_q[$];
    logic [7:0] got4_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp4_q[$];
    int done_cyc, done_cnt, done4_cyc, busy_first, busy_last, valid_first;
    int idle_cyc, stall_err, reg_num_c1, timed_out;

    task automatic build_expected();
        exp_q.delete();
        exp4_q.delete();
        for (int r = 0; r < 32; r++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(regs[r][b*8 +: 8]);
                if (r < 4) exp4_q.push_back(regs[r][b*8 +: 8]);
            end
        end
    endtask

    function automatic int mismatches(input logic [7:0] a[$], input logic [7:0] b[$]);
        int n = 0;
        if (a.size() != b.size()) return 9999;
        for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    // One dump, started at edge E0. Optional events (0 = none): a stray
    // start, an abort, an asynchronous reset, and a reg-7 overwrite, each
    // at the given cycle. rand_ready gives ~30% ready duty.
    task automatic run_dump(input int extra_start_at, input int abort_at,
                            input int reset_at, input int snap_at, input bit rand_ready);
        int  cyc;
        bit  finished;
        bit  prev_stall;
        bit  rdy;
        logic [7:0] prev_data;
        got_q.delete();
        got4_q.delete();
        done_cyc = 0; done_cnt = 0; done4_cyc = 0; busy_first = 0; busy_last = 0;
        valid_first = 0; idle_cyc = 0; stall_err = 0; reg_num_c1 = -1; timed_out = 0;
        prev_stall = 0; prev_data = '0; finished = 0; cyc = 0;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (reset_at == cyc) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_reset_busy",  {31'd0, busy},     32'd0);
                check("async_reset_valid", {31'd0, tx_valid}, 32'd0);
                check("async_reset_data",  {24'd0, tx_data},  32'd0);
                check("async_reset_regno", {27'd0, reg_num},  32'd0);
                check("async_reset_done",  {31'd0, done},     32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                finished = 1;
            end else begin
                if (cyc == 1) reg_num_c1 = int'(reg_num);
                if (busy) begin
                    if (busy_first == 0) busy_first = cyc;
                    busy_last = cyc;
                end
                if (tx_valid && valid_first == 0) valid_first = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (done4 && done4_cyc == 0) done4_cyc = cyc;
                if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;

                start = (cyc == extra_start_at);
                abort = (cyc == abort_at);
                rdy = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
                if (cyc == abort_at) rdy = 1'b0;
                tx_ready = rdy;
                if (tx_valid && rdy) got_q.push_back(tx_data);
                if (tx_valid4 && rdy) got4_q.push_back(tx_data4);
                prev_stall = tx_valid && !rdy && (cyc != abort_at);
                prev_data = tx_data;
                if (snap_at == cyc) regs[7] = 32'hDEAD_BEEF;
                if (!busy) begin
                    idle_cyc = cyc;
                    finished = 1;
                end
            end
        end
        if (!finished) timed_out = 1;
        check("no_timeout", timed_out, 0);
        start = 1'b0;
        abort = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        // Let the small instance settle back to idle before the next run.
        for (int i = 0; i < 30 && busy4; i++) @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'hA500_0000 + r;
        build_expected();

        // Reset state while reset is held.
        #2;
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_done",  {31'd0, done},     32'd0);
        check("rst_data",  {24'd0, tx_data},  32'd0);
        check("rst_regno", {27'd0, reg_num},  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic dump, ready held high.
        run_dump(0, 0, 0, 0, 1'b0);
        check("basic_nbytes",    got_q.size(), 128);
        check("basic_bytes",     mismatches(got_q, exp_q), 0);
        check("basic_reg3",      {got_q[12], got_q[13], got_q[14], got_q[15]}, 32'hA500_0003);
        check("basic_regno_c1",  reg_num_c1, 0);
        check("basic_valid_1st", valid_first, 2);
        check("basic_done_cyc",  done_cyc, 161);
        check("basic_done_cnt",  done_cnt, 1);
        check("basic_busy_1st",  busy_first, 1);
        check("basic_busy_last", busy_last, 161);
        check("basic_idle_cyc",  idle_cyc, 162);
        check("n4_nbytes",       got4_q.size(), 16);
        check("n4_bytes",        mismatches(got4_q, exp4_q), 0);
        check("n4_done_cyc",     done4_cyc, 21);

        // Random backpressure.
        run_dump(0, 0, 0, 0, 1'b1);
        check("bp_bytes",    mismatches(got_q, exp_q), 0);
        check("bp_stable",   stall_err, 0);
        check("bp_done_cnt", done_cnt, 1);

        // Abort after two bytes of reg 5 (reg 5 bytes are cycles 27..30).
        run_dump(0, 29, 0, 0, 1'b0);
        check("abort_nbytes",    got_q.size(), 22);
        check("abort_done_cnt",  done_cnt, 0);
        check("abort_busy_last", busy_last, 29);
        check("abort_idle_cyc",  idle_cyc, 30);

        // Restart after abort begins at reg 0.
        run_dump(0, 0, 0, 0, 1'b0);
        check("restart_regno_c1", reg_num_c1, 0);
        check("restart_bytes",    mismatches(got_q, exp_q), 0);

        // Start while busy is ignored.
        run_dump(40, 0, 0, 0, 1'b0);
        check("busy_start_bytes",    mismatches(got_q, exp_q), 0);
        check("busy_start_done_cyc", done_cyc, 161);
        check("busy_start_done_cnt", done_cnt, 1);

        // Asynchronous reset mid-SEND, then a clean dump.
        run_dump(0, 0, 12, 0, 1'b0);
        run_dump(0, 0, 0, 0, 1'b0);
        check("post_reset_bytes",    mismatches(got_q, exp_q), 0);
        check("post_reset_done_cyc", done_cyc, 161);

        // Overwrite reg 7 while it is being sent (reg 7 bytes: cycles 37..40).
        run_dump(0, 0, 0, 37, 1'b0);
        check("snap_bytes", mismatches(got_q, exp_q), 0);
        check("snap_reg7",  {got_q[28], got_q[29], got_q[30], got_q[31]}, 32'hA500_0007);
        regs[7] = 32'hA500_0007;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
